// File: rtl/mdio_apb_master.sv
// mdio_apb_master: turns single MDIO register commands into APB3 transfers.
// One transfer in flight at a time. Read data and error come back as a
// one-cycle rsp_valid pulse.
// Optional build macro: MDIO_APB_TIMEOUT_EN adds a PREADY watchdog that aborts
// an ACCESS phase after TIMEOUT_CYC cycles. Without it, ACCESS waits
// indefinitely and TIMEOUT_CYC is unused.
module mdio_apb_master #(
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] req_paddr,
  output logic              req_pwrite,
  output logic              req_psel,
  output logic              req_penable,
  output logic [DATA_W-1:0] req_pwdata,
  input  logic              req_pready,
  input  logic [DATA_W-1:0] req_prdata,
  input  logic              req_pslverr,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state;
  logic   timeout_hit;

`ifdef MDIO_APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment; the abort fires on the cycle the count would reach
  // TIMEOUT_CYC, i.e. after TIMEOUT_CYC ACCESS cycles without PREADY.
  always_comb begin
    cnt_inc     = (wait_cnt == CNT_W'(TIMEOUT_CYC)) ? wait_cnt : wait_cnt + 1'b1;
    timeout_hit = (cnt_inc >= CNT_W'(TIMEOUT_CYC));
  end
`else
  // No watchdog: ACCESS only ends on PREADY.
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  // Transfer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      req_paddr   <= '0;
      req_pwrite  <= 1'b0;
      req_psel    <= 1'b0;
      req_penable <= 1'b0;
      req_pwdata  <= '0;
`ifdef MDIO_APB_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            req_paddr  <= cmd_addr;
            req_pwrite <= cmd_write;
            req_pwdata <= cmd_write ? cmd_wdata : '0;
            req_psel   <= 1'b1;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= S_SETUP;
          end
        end

        S_SETUP: begin
          req_penable <= 1'b1;
`ifdef MDIO_APB_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
          state       <= S_ACCESS;
        end

        S_ACCESS: begin
          if (req_pready) begin
            // Read data only for error-free reads; writes and errors return 0.
            rsp_rdata   <= (!req_pwrite && !req_pslverr) ? req_prdata : '0;
            rsp_err     <= req_pslverr;
            rsp_valid   <= 1'b1;
            req_psel    <= 1'b0;
            req_penable <= 1'b0;
            state       <= S_RESP;
          end else if (timeout_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_valid   <= 1'b1;
            req_psel    <= 1'b0;
            req_penable <= 1'b0;
            state       <= S_RESP;
          end else begin
`ifdef MDIO_APB_TIMEOUT_EN
            wait_cnt    <= cnt_inc;
`endif
          end
        end

        S_RESP: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_apb_master.sv
// Testbench for mdio_apb_master: table of APB transfers driven through a
// cycle-accurate slave model, plus hand-written reset / back-to-back /
// watchdog sequences. Responses are checked through a scoreboard queue.
module tb_mdio_apb_master;

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned TB_TCYC = 8;

  // {psel, penable, cmd_ready, busy, rsp_valid}
  localparam logic [4:0] CTL_IDLE   = 5'b00100;
  localparam logic [4:0] CTL_SETUP  = 5'b10010;
  localparam logic [4:0] CTL_ACCESS = 5'b11010;
  localparam logic [4:0] CTL_RESP   = 5'b00011;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] req_paddr;
  logic              req_pwrite;
  logic              req_psel;
  logic              req_penable;
  logic [DATA_W-1:0] req_pwdata;
  logic              req_pready;
  logic [DATA_W-1:0] req_prdata;
  logic              req_pslverr;
  logic              busy;

  mdio_apb_master #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TB_TCYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .req_paddr   (req_paddr),
    .req_pwrite  (req_pwrite),
    .req_psel    (req_psel),
    .req_penable (req_penable),
    .req_pwdata  (req_pwdata),
    .req_pready  (req_pready),
    .req_prdata  (req_prdata),
    .req_pslverr (req_pslverr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Expected {rsp_rdata, rsp_err}, pushed at command acceptance.
  logic [DATA_W:0] sb_q[$];

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int unsigned       ws;
    logic [DATA_W-1:0] prdata;
    logic              slverr;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [4:0] ctl();
    return {req_psel, req_penable, cmd_ready, busy, rsp_valid};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        logic [DATA_W:0] e;
        e = sb_q.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(e[DATA_W:1]));
        check("rsp_err", 32'(rsp_err), 32'(e[0]));
      end
    end
  end

  // Must be called at a falling edge; returns at a falling edge with the DUT idle.
  task automatic run_txn(input vec_t v, input bit hold);
    int unsigned       acc;
    logic [DATA_W-1:0] er;
    logic              ee;
    bit                accepted;
    acc = v.ws + 1;
    er  = v.exp_rdata;
    ee  = v.exp_err;
`ifdef MDIO_APB_TIMEOUT_EN
    if (v.ws >= TB_TCYC) begin
      acc = TB_TCYC;
      er  = '0;
      ee  = 1'b1;
    end
`endif
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_valid = 1'b1;
    accepted  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready === 1'b1) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      check("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    check("idle_before_accept", 32'(ctl()), 32'(CTL_IDLE));
    @(posedge clk);
    sb_q.push_back({er, ee});
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    // SETUP: PREADY driven high here must be ignored.
    check("setup_ctl", 32'(ctl()), 32'(CTL_SETUP));
    check("setup_paddr", 32'(req_paddr), 32'(v.addr));
    check("setup_pwrite", 32'(req_pwrite), 32'(v.wr));
    check("setup_pwdata", 32'(req_pwdata), v.wr ? 32'(v.wdata) : 32'd0);
    req_pready  = 1'b1;
    req_prdata  = DATA_W'($urandom);
    req_pslverr = 1'b1;
    @(negedge clk);
    for (int unsigned k = 0; k < acc; k++) begin
      check("access_ctl", 32'(ctl()), 32'(CTL_ACCESS));
      check("access_paddr", 32'(req_paddr), 32'(v.addr));
      check("access_pwrite", 32'(req_pwrite), 32'(v.wr));
      check("access_pwdata", 32'(req_pwdata), v.wr ? 32'(v.wdata) : 32'd0);
      if (k == v.ws) begin
        req_pready  = 1'b1;
        req_prdata  = v.prdata;
        req_pslverr = v.slverr;
      end else begin
        req_pready  = 1'b0;
        req_prdata  = DATA_W'($urandom);
        req_pslverr = 1'($urandom);
      end
      @(negedge clk);
    end
    req_pready  = 1'b0;
    req_pslverr = 1'b0;
    check("resp_ctl", 32'(ctl()), 32'(CTL_RESP));
    @(negedge clk);
    check("back_to_idle_ctl", 32'(ctl()), 32'(CTL_IDLE));
    check("rsp_rdata_held", 32'(rsp_rdata), 32'(er));
    check("rsp_err_held", 32'(rsp_err), 32'(ee));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t hv;

    //          wr    addr        wdata    ws prdata   err   exp_rd   exp_err
    tbl[0] = '{1'b1, 21'h00010,  16'hA5A5, 0, 16'hDEAD, 1'b0, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 21'h1FFFFF, 16'hFFFF, 3, 16'h1234, 1'b0, 16'h1234, 1'b0};
    tbl[2] = '{1'b0, 21'h00ABC,  16'h0000, 0, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
    tbl[3] = '{1'b1, 21'h0F00F,  16'h1357, 1, 16'h2468, 1'b1, 16'h0000, 1'b1};
    tbl[4] = '{1'b0, 21'h00000,  16'h0000, 0, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0};
    tbl[5] = '{1'b1, 21'h155555, 16'h5A5A, 2, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
    tbl[6] = '{1'b0, 21'h0AAAAA, 16'h0000, 7, 16'h8001, 1'b0, 16'h8001, 1'b0};

    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    req_pready  = 1'b0;
    req_prdata  = '0;
    req_pslverr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctl", 32'(ctl()), 32'(CTL_IDLE));
    check("reset_paddr", 32'(req_paddr), 32'd0);
    check("reset_pwdata", 32'(req_pwdata), 32'd0);
    check("reset_pwrite", 32'(req_pwrite), 32'd0);
    check("reset_rsp", 32'({rsp_rdata, rsp_err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_txn(tbl[i], 1'b0);

    // Long stall: normal completion without watchdog, abort with it.
    hv = '{1'b0, 21'h012345, 16'h0000, 40, 16'h7E7E, 1'b0, 16'h7E7E, 1'b0};
    run_txn(hv, 1'b0);

    // Reset in the middle of ACCESS: transfer vanishes, no response.
    cmd_write = 1'b0;
    cmd_addr  = 21'h000777;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_access", 32'(ctl()), 32'(CTL_ACCESS));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_ctl", 32'(ctl()), 32'(CTL_IDLE));
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("after_reset_quiet", 32'(ctl()), 32'(CTL_IDLE));
    end
    run_txn(tbl[4], 1'b0);

    // cmd_valid held across two commands: second waits for cmd_ready.
    run_txn(tbl[0], 1'b1);
    run_txn(tbl[0], 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
